seg_shift_ctrl: RTL and testbench

- Sequencer for the 8-digit serial seven-segment display path.
- Steps the segment mapper's scan index, captures each returned 8-bit segment byte, and shifts it MSB-first into the board's external shift-register chain.
- Pulses the display latch once all bytes are shifted out.
- Sits between the display data/mapper logic and the display pins: seg_clk, seg_sout, seg_latch, seg_clrn.

---
 rtl/seg_shift_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_seg_shift_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_shift_ctrl.sv
// Frame sequencer for the serial seven-segment chain: scans the mapper, shifts bytes MSB-first, latches.
// Optional macro SEG_AUTO_REFRESH_EN adds a free-running REFRESH-cycle frame request.

module seg_shift_ctrl #(
    parameter int CLK_DIV   = 1,
    parameter int NUM_BYTES = 8,
    parameter int REFRESH   = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] seg_byte,
    output logic [2:0] scan,
    output logic       seg_clk,
    output logic       seg_sout,
    output logic       seg_latch,
    output logic       seg_clrn,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [2:0] SCAN_LAST = 3'(NUM_BYTES - 1);

    if (CLK_DIV < 1 || CLK_DIV > 255 || NUM_BYTES < 1 || NUM_BYTES > 8 || REFRESH < 1) begin : g_bad_params
        $error("seg_shift_ctrl: CLK_DIV, NUM_BYTES or REFRESH out of range");
    end

    state_t     state_q, state_d;
    logic [2:0] scan_q, scan_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] divcnt_q, divcnt_d;
    logic       seg_clk_q, seg_clk_d;
    logic       seg_latch_q, seg_latch_d;
    logic       seg_clrn_q, seg_clrn_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       div_end;
    logic       frame_req;
    logic       accept;

    assign div_end = (divcnt_q == DIV_LAST);
    assign accept  = (state_q == S_IDLE) && frame_req;

`ifdef SEG_AUTO_REFRESH_EN
    localparam logic [31:0] REFRESH_LAST = 32'(REFRESH - 1);

    logic [31:0] refresh_cnt_q, refresh_cnt_d;
    logic        refresh_pend_q, refresh_pend_d;
    logic        refresh_wrap;

    assign refresh_wrap = (refresh_cnt_q == REFRESH_LAST);
    assign frame_req    = start | refresh_pend_q;

    // A single pending flag: a wrap while one is already pending collapses into it.
    always_comb begin
        refresh_cnt_d  = refresh_wrap ? '0 : refresh_cnt_q + 32'd1;
        refresh_pend_d = refresh_wrap | (refresh_pend_q & ~accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_q  <= '0;
            refresh_pend_q <= 1'b0;
        end else begin
            refresh_cnt_q  <= refresh_cnt_d;
            refresh_pend_q <= refresh_pend_d;
        end
    end
`else
    assign frame_req = start;
`endif

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the case infers a latch.
        state_d     = state_q;
        scan_d      = scan_q;
        sr_d        = sr_q;
        bitcnt_d    = bitcnt_q;
        divcnt_d    = divcnt_q;
        seg_clk_d   = seg_clk_q;
        seg_latch_d = seg_latch_q;
        seg_clrn_d  = ~rst;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    scan_d  = '0;
                end
            end
            S_LOAD: begin
                // The mapper has had this whole cycle to settle on the current scan.
                sr_d      = seg_byte;
                bitcnt_d  = '0;
                divcnt_d  = '0;
                seg_clk_d = 1'b0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (!div_end) begin
                    divcnt_d = divcnt_q + 8'd1;
                end else begin
                    divcnt_d = '0;
                    if (!seg_clk_q) begin
                        seg_clk_d = 1'b1;
                    end else begin
                        // Data moves on the same edge seg_clk falls, so it is stable across every rise.
                        seg_clk_d = 1'b0;
                        sr_d      = {sr_q[6:0], 1'b0};
                        bitcnt_d  = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (scan_q == SCAN_LAST) begin
                                state_d     = S_LATCH;
                                seg_latch_d = 1'b1;
                            end else begin
                                scan_d  = scan_q + 3'd1;
                                state_d = S_LOAD;
                            end
                        end
                    end
                end
            end
            S_LATCH: begin
                if (!div_end) begin
                    divcnt_d = divcnt_q + 8'd1;
                end else begin
                    divcnt_d    = '0;
                    seg_latch_d = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    scan_d      = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state updates use <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            scan_q      <= '0;
            sr_q        <= '0;
            bitcnt_q    <= '0;
            divcnt_q    <= '0;
            seg_clk_q   <= 1'b0;
            seg_latch_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_q      <= scan_d;
            sr_q        <= sr_d;
            bitcnt_q    <= bitcnt_d;
            divcnt_q    <= divcnt_d;
            seg_clk_q   <= seg_clk_d;
            seg_latch_q <= seg_latch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
        seg_clrn_q <= seg_clrn_d;
    end

    // sr is empty outside SHIFT, so its MSB is also the idle/latch value of seg_sout.
    assign scan      = scan_q;
    assign seg_clk   = seg_clk_q;
    assign seg_sout  = sr_q[7];
    assign seg_latch = seg_latch_q;
    assign seg_clrn  = seg_clrn_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seg_shift_ctrl.sv
// Scoreboard bench for seg_shift_ctrl: expected serial bits are queued at stimulus time and
// popped at every observed seg_clk rise; frame timing is checked against the closed-form latency.

module tb_seg_shift_ctrl;

    localparam int A_DIV  = 1;
    localparam int A_NUM  = 8;
    localparam int A_LAT  = A_NUM * (1 + 16 * A_DIV) + A_DIV + 1;
    localparam int B_DIV  = 3;
    localparam int B_NUM  = 2;
    localparam int B_LAT  = B_NUM * (1 + 16 * B_DIV) + B_DIV + 1;
    localparam int B_FIRST_RISE = 1 + B_DIV + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic       start_a, ovr_en;
    logic [7:0] byte_a, ovr_val;
    logic [2:0] scan_a;
    logic       seg_clk_a, seg_sout_a, seg_latch_a, seg_clrn_a, busy_a, done_a;

    logic       start_b;
    logic [7:0] byte_b;
    logic [2:0] scan_b;
    logic       seg_clk_b, seg_sout_b, seg_latch_b, seg_clrn_b, busy_b, done_b;

    logic exp_qa[$];
    logic exp_qb[$];

    // Mapper stub: A5 ^ scan unless a test overrides the byte.
    always_comb byte_a = ovr_en ? ovr_val : (8'hA5 ^ {5'd0, scan_a});

    seg_shift_ctrl #(.CLK_DIV(A_DIV), .NUM_BYTES(A_NUM), .REFRESH(50000)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .seg_byte(byte_a), .scan(scan_a),
        .seg_clk(seg_clk_a), .seg_sout(seg_sout_a), .seg_latch(seg_latch_a),
        .seg_clrn(seg_clrn_a), .busy(busy_a), .done(done_a)
    );

    seg_shift_ctrl #(.CLK_DIV(B_DIV), .NUM_BYTES(B_NUM), .REFRESH(50000)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .seg_byte(byte_b), .scan(scan_b),
        .seg_clk(seg_clk_b), .seg_sout(seg_sout_b), .seg_latch(seg_latch_b),
        .seg_clrn(seg_clrn_b), .busy(busy_b), .done(done_b)
    );

`ifdef SEG_AUTO_REFRESH_EN
    logic       start_r;
    logic [7:0] byte_r;
    logic [2:0] scan_r;
    logic       seg_clk_r, seg_sout_r, seg_latch_r, seg_clrn_r, busy_r, done_r;

    seg_shift_ctrl #(.CLK_DIV(1), .NUM_BYTES(8), .REFRESH(200)) dut_r (
        .clk(clk), .rst(rst), .start(start_r), .seg_byte(byte_r), .scan(scan_r),
        .seg_clk(seg_clk_r), .seg_sout(seg_sout_r), .seg_latch(seg_latch_r),
        .seg_clrn(seg_clrn_r), .busy(busy_r), .done(done_r)
    );
`endif

    function automatic logic [7:0] hold_val(input int c);
        return 8'((c * 37 + 11) & 255);
    endfunction

    // Runs one frame on dut_a from the current negedge; pops the scoreboard at every seg_clk rise.
    task automatic run_frame_a(input bit hold, input int ex0, input int ex1, input int ex2,
                               output int lat, output int rises, output int latch_cycles,
                               output int busy_err, output logic busy_at_done, output int dones);
        logic prev_clk;
        logic e;
        lat = 0; rises = 0; latch_cycles = 0; busy_err = 0; busy_at_done = 1'bx; dones = 0;
        prev_clk = 1'b0;
        ovr_en  = hold;
        ovr_val = hold_val(0);
        start_a = 1'b1;
        for (int cyc = 1; cyc <= A_LAT + 3; cyc++) begin
            @(negedge clk);
            if (seg_clk_a && !prev_clk) begin
                rises++;
                total++;
                if (exp_qa.size() == 0) begin
                    bad++;
                    $display("FAIL sout_a: unexpected seg_clk rise %0d at cycle %0d", rises, cyc);
                end else begin
                    e = exp_qa.pop_front();
                    if (seg_sout_a !== e) begin
                        bad++;
                        $display("FAIL sout_a: rise %0d got %b want %b", rises, seg_sout_a, e);
                    end
                end
            end
            prev_clk = seg_clk_a;
            if (seg_latch_a) latch_cycles++;
            if (done_a) begin
                dones++;
                if (lat == 0) begin
                    lat = cyc;
                    busy_at_done = busy_a;
                end
            end else if (lat == 0 && busy_a !== 1'b1) begin
                busy_err++;
            end
            start_a = (cyc == ex0) || (cyc == ex1) || (cyc == ex2);
            ovr_val = hold_val(cyc);
        end
        start_a = 1'b0;
        ovr_en  = 1'b0;
    endtask

    task automatic test_reset();
        int events;
        total++;
        if ({scan_a, seg_clk_a, seg_sout_a, seg_latch_a, seg_clrn_a, busy_a, done_a} !== 9'd0) begin
            bad++;
            $display("FAIL rst_vals_a: got %b want 0", {scan_a, seg_clk_a, seg_sout_a, seg_latch_a, seg_clrn_a, busy_a, done_a});
        end
        total++;
        if ({scan_b, seg_clk_b, seg_sout_b, seg_latch_b, seg_clrn_b, busy_b, done_b} !== 9'd0) begin
            bad++;
            $display("FAIL rst_vals_b: got %b want 0", {scan_b, seg_clk_b, seg_sout_b, seg_latch_b, seg_clrn_b, busy_b, done_b});
        end
        rst = 1'b0;
        #1;
        total++;
        if (seg_clrn_a !== 1'b0) begin
            bad++;
            $display("FAIL clrn_before_edge: got %b want 0", seg_clrn_a);
        end
        @(negedge clk);
        total++;
        if (seg_clrn_a !== 1'b1 || seg_clrn_b !== 1'b1) begin
            bad++;
            $display("FAIL clrn_release: got %b%b want 11", seg_clrn_a, seg_clrn_b);
        end

        // Abort a frame in the middle of the second byte.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (busy_a !== 1'b1 || seg_clrn_a !== 1'b1) begin
            bad++;
            $display("FAIL busy_before_abort: got busy=%b clrn=%b want 1 1", busy_a, seg_clrn_a);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({scan_a, seg_clk_a, seg_sout_a, seg_latch_a, seg_clrn_a, busy_a, done_a} !== 9'd0) begin
            bad++;
            $display("FAIL abort_vals: got %b want 0", {scan_a, seg_clk_a, seg_sout_a, seg_latch_a, seg_clrn_a, busy_a, done_a});
        end
        events = 0;
        repeat (2) begin
            @(negedge clk);
            if (done_a || seg_latch_a || busy_a || seg_clrn_a) events++;
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (seg_clrn_a !== 1'b1 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL abort_release: got clrn=%b busy=%b want 1 0", seg_clrn_a, busy_a);
        end
        repeat (200) begin
            @(negedge clk);
            if (done_a || seg_latch_a || seg_clk_a || busy_a) events++;
        end
        total++;
        if (events != 0) begin
            bad++;
            $display("FAIL abort_quiet: got %0d activity cycles want 0", events);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        int   lat, rises, lcyc, berr, ndone;
        logic bdone;
        exp_qa.delete();
        for (int k = 0; k < A_NUM; k++) begin
            b = 8'hA5 ^ 8'(k);
            for (int i = 7; i >= 0; i--) exp_qa.push_back(b[i]);
        end
        run_frame_a(1'b0, 0, 0, 0, lat, rises, lcyc, berr, bdone, ndone);
        total++;
        if (lat != A_LAT) begin bad++; $display("FAIL single_latency: got %0d want %0d", lat, A_LAT); end
        total++;
        if (rises != 8 * A_NUM) begin bad++; $display("FAIL single_rises: got %0d want %0d", rises, 8 * A_NUM); end
        total++;
        if (lcyc != A_DIV) begin bad++; $display("FAIL single_latch: got %0d cycles want %0d", lcyc, A_DIV); end
        total++;
        if (ndone != 1 || bdone !== 1'b0) begin
            bad++;
            $display("FAIL single_done: got dones=%0d busy_at_done=%b want 1 0", ndone, bdone);
        end
        total++;
        if (berr != 0) begin bad++; $display("FAIL single_busy: got %0d low cycles want 0", berr); end
        total++;
        if (exp_qa.size() != 0) begin bad++; $display("FAIL single_leftover: got %0d bits want 0", exp_qa.size()); end
    endtask

    task automatic test_ignored_start();
        logic [7:0] b;
        int   lat, rises, lcyc, berr, ndone, idle_err;
        logic bdone;
        exp_qa.delete();
        for (int k = 0; k < A_NUM; k++) begin
            b = 8'hA5 ^ 8'(k);
            for (int i = 7; i >= 0; i--) exp_qa.push_back(b[i]);
        end
        run_frame_a(1'b0, 5, 60, A_LAT, lat, rises, lcyc, berr, bdone, ndone);
        idle_err = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy_a || seg_clk_a || done_a) idle_err++;
        end
        total++;
        if (lat != A_LAT || ndone != 1) begin
            bad++;
            $display("FAIL ign_done: got lat=%0d dones=%0d want %0d 1", lat, ndone, A_LAT);
        end
        total++;
        if (bdone !== 1'b0 || berr != 0) begin
            bad++;
            $display("FAIL ign_busy: got busy_at_done=%b low_cycles=%0d want 0 0", bdone, berr);
        end
        total++;
        if (idle_err != 0 || rises != 8 * A_NUM) begin
            bad++;
            $display("FAIL ign_second_frame: got idle_err=%0d rises=%0d want 0 %0d", idle_err, rises, 8 * A_NUM);
        end
    endtask

    task automatic test_data_hold();
        logic [7:0] b;
        int   lat, rises, lcyc, berr, ndone;
        logic bdone;
        exp_qa.delete();
        // Byte k is captured at the end of its LOAD cycle, cycle 1 + k*(1+16*CLK_DIV).
        for (int k = 0; k < A_NUM; k++) begin
            b = hold_val(1 + k * (1 + 16 * A_DIV));
            for (int i = 7; i >= 0; i--) exp_qa.push_back(b[i]);
        end
        run_frame_a(1'b1, 0, 0, 0, lat, rises, lcyc, berr, bdone, ndone);
        total++;
        if (lat != A_LAT || rises != 8 * A_NUM) begin
            bad++;
            $display("FAIL hold_frame: got lat=%0d rises=%0d want %0d %0d", lat, rises, A_LAT, 8 * A_NUM);
        end
        total++;
        if (exp_qa.size() != 0) begin bad++; $display("FAIL hold_leftover: got %0d bits want 0", exp_qa.size()); end
    endtask

    task automatic test_clock_div();
        int   lat, rises, hi_run, hi_err, sp_err, scan_err, lcyc, want_sp;
        int   rise_cyc[$];
        logic prev, e;
        lat = 0; rises = 0; hi_run = 0; hi_err = 0; sp_err = 0; scan_err = 0; lcyc = 0; prev = 1'b0;
        exp_qb.delete();
        for (int k = 0; k < B_NUM; k++)
            for (int i = 7; i >= 0; i--) exp_qb.push_back(byte_b[i]);
        start_b = 1'b1;
        for (int cyc = 1; cyc <= B_LAT + 5; cyc++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (seg_clk_b && !prev) begin
                rises++;
                rise_cyc.push_back(cyc);
                total++;
                if (exp_qb.size() == 0) begin
                    bad++;
                    $display("FAIL sout_b: unexpected seg_clk rise %0d at cycle %0d", rises, cyc);
                end else begin
                    e = exp_qb.pop_front();
                    if (seg_sout_b !== e) begin
                        bad++;
                        $display("FAIL sout_b: rise %0d got %b want %b", rises, seg_sout_b, e);
                    end
                end
            end
            if (seg_clk_b) hi_run++;
            else begin
                if (prev && hi_run != B_DIV) hi_err++;
                hi_run = 0;
            end
            prev = seg_clk_b;
            if (seg_latch_b) lcyc++;
            if (scan_b > 3'(B_NUM - 1)) scan_err++;
            if (done_b && lat == 0) lat = cyc;
        end
        for (int i = 1; i < rise_cyc.size(); i++) begin
            want_sp = (i % 8 == 0) ? 2 * B_DIV + 1 : 2 * B_DIV;
            if (rise_cyc[i] - rise_cyc[i-1] != want_sp) sp_err++;
        end
        total++;
        if (lat != B_LAT) begin bad++; $display("FAIL div_latency: got %0d want %0d", lat, B_LAT); end
        total++;
        if (rises != 8 * B_NUM) begin bad++; $display("FAIL div_rises: got %0d want %0d", rises, 8 * B_NUM); end
        total++;
        if (rise_cyc.size() == 0 || rise_cyc[0] != B_FIRST_RISE) begin
            bad++;
            $display("FAIL div_first_rise: got %0d want %0d", (rise_cyc.size() == 0) ? -1 : rise_cyc[0], B_FIRST_RISE);
        end
        total++;
        if (sp_err != 0 || hi_err != 0) begin
            bad++;
            $display("FAIL div_phases: got spacing_err=%0d high_err=%0d want 0 0", sp_err, hi_err);
        end
        total++;
        if (lcyc != B_DIV || scan_err != 0) begin
            bad++;
            $display("FAIL div_latch_scan: got latch=%0d scan_err=%0d want %0d 0", lcyc, scan_err, B_DIV);
        end
    endtask

`ifdef SEG_AUTO_REFRESH_EN
    task automatic test_auto_refresh();
        int   rise[$];
        int   d, t_start;
        logic prev;
        d = 0; t_start = -1; prev = busy_r;
        for (int cyc = 1; cyc <= 900; cyc++) begin
            @(negedge clk);
            if (busy_r && !prev) rise.push_back(cyc);
            prev = busy_r;
            if (rise.size() == 2 && t_start < 0) t_start = rise[1] + 150;
            start_r = (cyc == t_start);
            if (done_r && t_start > 0 && cyc > t_start && d == 0) d = cyc;
            if (d > 0 && cyc == d + 3) break;
        end
        start_r = 1'b0;
        total++;
        if (rise.size() < 2 || rise[1] - rise[0] != 200) begin
            bad++;
            $display("FAIL refresh_period: got %0d frames/%0d spacing want 200", rise.size(), (rise.size() < 2) ? -1 : rise[1] - rise[0]);
        end
        total++;
        if (rise.size() < 4 || rise[3] != d + 2) begin
            bad++;
            $display("FAIL refresh_pending: got restart %0d want %0d", (rise.size() < 4) ? -1 : rise[3], d + 2);
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ovr_en  = 1'b0;
        ovr_val = 8'h00;
        byte_b  = 8'hFF;
`ifdef SEG_AUTO_REFRESH_EN
        start_r = 1'b0;
        byte_r  = 8'h81;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        test_single_frame();
        test_ignored_start();
        test_data_hold();
        test_clock_div();
`ifdef SEG_AUTO_REFRESH_EN
        test_auto_refresh();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
